// File: rtl/sram22_pkg.sv
// -----------------------------------------------------------------------------
// sram22_pkg
// Shared types and helpers for the sram22 generated-macro memory model.
//   sram_init_state_e        : INIT (post-reset sweep running) / READY
//   lane_width()             : bits per write-mask lane
//   `SRAM22_CHECK_PARAMS     : elaboration-time geometry legality check,
//                              expanded inside a module body
// -----------------------------------------------------------------------------
`ifndef SRAM22_PKG_SV
`define SRAM22_PKG_SV

`define SRAM22_CHECK_PARAMS(DW, MW) \
   if (((DW) % (MW)) != 0) begin : g_bad_params \
      $error("sram22: DATA_WIDTH must be a multiple of WMASK_WIDTH"); \
   end

package sram22_pkg;

   typedef enum logic {
      INIT  = 1'b0,
      READY = 1'b1
   } sram_init_state_e;

   function automatic int lane_width(input int data_width, input int wmask_width);
      return data_width / wmask_width;
   endfunction

endpackage

`endif

// File: rtl/sram22_init_seq.sv
// -----------------------------------------------------------------------------
// sram22_init_seq
// Post-reset initialisation sequencer. After rstb releases it steps init_ptr
// through every address, one per clock, then parks in READY until the next
// reset.
// Ports:
//   clk        in   clock
//   rstb       in   asynchronous active-low reset
//   init_busy  out  high while the sweep is running
//   init_we    out  write strobe for the init port of the array
//   init_addr  out  address being initialised this cycle
// -----------------------------------------------------------------------------
module sram22_init_seq
   import sram22_pkg::*;
#(
   parameter int ADDR_WIDTH = 7
) (
   input  logic                  clk,
   input  logic                  rstb,
   output logic                  init_busy,
   output logic                  init_we,
   output logic [ADDR_WIDTH-1:0] init_addr
);

   sram_init_state_e      r_state;
   logic [ADDR_WIDTH-1:0] r_init_ptr;
   logic                  r_init_busy;

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values; blocking here would make r_init_busy see the updated ptr.
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         r_state     <= INIT;
         r_init_ptr  <= '0;
         r_init_busy <= 1'b1;
      end else begin
         case (r_state)
            INIT: begin
               r_init_ptr <= r_init_ptr + ADDR_WIDTH'(1);
               // The edge that writes the last word also leaves INIT, so the
               // sweep is exactly DEPTH edges long.
               if (r_init_ptr == {ADDR_WIDTH{1'b1}}) begin
                  r_state     <= READY;
                  r_init_busy <= 1'b0;
               end
            end
            READY: begin
               r_state <= READY;
            end
         endcase
      end
   end

   assign init_busy = r_init_busy;
   assign init_we   = r_init_busy;
   assign init_addr = r_init_ptr;

endmodule

// File: rtl/sram22_mem_model_gen2.sv
// -----------------------------------------------------------------------------
// sram22_mem_model_gen2
// Parametrised single-port SRAM behavioural model with per-lane write mask,
// post-reset INIT_VALUE sweep, optional output register and read-valid strobe.
// Ports:
//   clk        in   clock, all state updates on rising edge
//   rstb       in   asynchronous active-low reset
//   ce         in   chip enable (ignored while init_busy)
//   we         in   1 = write, 0 = read
//   wmask      in   per-lane write enable, lane i = bits [i*LW +: LW]
//   addr       in   word address
//   din        in   write data
//   dout       out  read data, holds between reads
//   rd_valid   out  one-cycle pulse aligned with new dout
//   init_busy  out  init sweep running, requests dropped
// -----------------------------------------------------------------------------
module sram22_mem_model_gen2
   import sram22_pkg::*;
#(
   parameter int                    DATA_WIDTH  = 40,
   parameter int                    ADDR_WIDTH  = 7,
   parameter int                    WMASK_WIDTH = 2,
   parameter int                    OUT_REG     = 0,
   parameter logic [DATA_WIDTH-1:0] INIT_VALUE  = '0
) (
   input  logic                   clk,
   input  logic                   rstb,
   input  logic                   ce,
   input  logic                   we,
   input  logic [WMASK_WIDTH-1:0] wmask,
   input  logic [ADDR_WIDTH-1:0]  addr,
   input  logic [DATA_WIDTH-1:0]  din,
   output logic [DATA_WIDTH-1:0]  dout,
   output logic                   rd_valid,
   output logic                   init_busy
);

   localparam int LW    = lane_width(DATA_WIDTH, WMASK_WIDTH);
   localparam int DEPTH = 2 ** ADDR_WIDTH;

   `SRAM22_CHECK_PARAMS(DATA_WIDTH, WMASK_WIDTH)

   logic                  w_init_busy;
   logic                  w_init_we;
   logic [ADDR_WIDTH-1:0] w_init_addr;
   logic                  w_user_wr;
   logic                  w_user_rd;

   sram22_init_seq #(
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_init_seq (
      .clk       (clk),
      .rstb      (rstb),
      .init_busy (w_init_busy),
      .init_we   (w_init_we),
      .init_addr (w_init_addr)
   );

   // User requests are gated off entirely while the sweep owns the array.
   assign w_user_wr = ce &  we & ~w_init_busy;
   assign w_user_rd = ce & ~we & ~w_init_busy;

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];

   // NOTE: the array has no reset; its post-reset contents come from the init
   // sweep, which keeps it mappable onto a real macro.
   always_ff @(posedge clk) begin
      if (w_init_we) begin
         r_mem[w_init_addr] <= INIT_VALUE;
      end else if (w_user_wr) begin
         for (int i = 0; i < WMASK_WIDTH; i++) begin
            if (wmask[i]) begin
               r_mem[addr][i*LW +: LW] <= din[i*LW +: LW];
            end
         end
      end
   end

   // First read stage: captures the word at the request edge. Data only
   // moves on a read so dout holds its value across idle and write cycles.
   logic [DATA_WIDTH-1:0] r_rd_data;
   logic                  r_rd_vld;

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         r_rd_data <= '0;
         r_rd_vld  <= 1'b0;
      end else begin
         r_rd_vld <= w_user_rd;
         if (w_user_rd) begin
            r_rd_data <= r_mem[addr];
         end
      end
   end

   if (OUT_REG != 0) begin : g_out_reg
      logic [DATA_WIDTH-1:0] r_dout;
      logic                  r_rd_valid;

      always_ff @(posedge clk or negedge rstb) begin
         if (!rstb) begin
            r_dout     <= '0;
            r_rd_valid <= 1'b0;
         end else begin
            r_rd_valid <= r_rd_vld;
            if (r_rd_vld) begin
               r_dout <= r_rd_data;
            end
         end
      end

      assign dout     = r_dout;
      assign rd_valid = r_rd_valid;
   end else begin : g_no_out_reg
      assign dout     = r_rd_data;
      assign rd_valid = r_rd_vld;
   end

   assign init_busy = w_init_busy;

endmodule

// File: tb/tb_sram22_mem_model_gen2.sv
// -----------------------------------------------------------------------------
// tb_sram22_mem_model_gen2
// Three instances share clk/rstb: d0 default geometry, d1 OUT_REG=1,
// d2 32-bit x 16 words with byte lanes and INIT_VALUE=32'hDEADBEEF.
// Inputs change just after a falling edge; outputs are sampled on the next
// falling edge, i.e. half a cycle after the capturing rising edge.
// -----------------------------------------------------------------------------
module tb_sram22_mem_model_gen2;

   logic clk = 1'b0;
   logic rstb = 1'b0;

   always #5 clk = ~clk;

   // d0: defaults
   logic        d0_ce = 1'b0, d0_we = 1'b0;
   logic [1:0]  d0_wmask = '0;
   logic [6:0]  d0_addr = '0;
   logic [39:0] d0_din = '0;
   logic [39:0] d0_dout;
   logic        d0_rd_valid, d0_init_busy;

   // d1: OUT_REG=1
   logic        d1_ce = 1'b0, d1_we = 1'b0;
   logic [1:0]  d1_wmask = '0;
   logic [6:0]  d1_addr = '0;
   logic [39:0] d1_din = '0;
   logic [39:0] d1_dout;
   logic        d1_rd_valid, d1_init_busy;

   // d2: geometry variant
   logic        d2_ce = 1'b0, d2_we = 1'b0;
   logic [3:0]  d2_wmask = '0;
   logic [3:0]  d2_addr = '0;
   logic [31:0] d2_din = '0;
   logic [31:0] d2_dout;
   logic        d2_rd_valid, d2_init_busy;

   sram22_mem_model_gen2 u_d0 (
      .clk(clk), .rstb(rstb), .ce(d0_ce), .we(d0_we), .wmask(d0_wmask),
      .addr(d0_addr), .din(d0_din), .dout(d0_dout), .rd_valid(d0_rd_valid),
      .init_busy(d0_init_busy)
   );

   sram22_mem_model_gen2 #(.OUT_REG(1)) u_d1 (
      .clk(clk), .rstb(rstb), .ce(d1_ce), .we(d1_we), .wmask(d1_wmask),
      .addr(d1_addr), .din(d1_din), .dout(d1_dout), .rd_valid(d1_rd_valid),
      .init_busy(d1_init_busy)
   );

   sram22_mem_model_gen2 #(
      .DATA_WIDTH(32), .ADDR_WIDTH(4), .WMASK_WIDTH(4), .INIT_VALUE(32'hDEADBEEF)
   ) u_d2 (
      .clk(clk), .rstb(rstb), .ce(d2_ce), .we(d2_we), .wmask(d2_wmask),
      .addr(d2_addr), .din(d2_din), .dout(d2_dout), .rd_valid(d2_rd_valid),
      .init_busy(d2_init_busy)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic d0_drive(input logic ce, input logic we, input logic [1:0] m,
                           input logic [6:0] a, input logic [39:0] d);
      d0_ce = ce; d0_we = we; d0_wmask = m; d0_addr = a; d0_din = d;
   endtask

   // Counts falling edges with init_busy high on each instance until all are
   // idle. With drop_reqs set, d0 gets write/read requests mid-sweep and a
   // read on the very last busy cycle; none of them may produce rd_valid.
   task automatic run_init(input bit drop_reqs, output int c0, output int c1,
                           output int c2, output bit saw_valid, output bit timeout);
      c0 = 0; c1 = 0; c2 = 0; saw_valid = 1'b0; timeout = 1'b1;
      for (int k = 0; k < 1000; k++) begin
         @(negedge clk);
         if (d0_rd_valid || d1_rd_valid || d2_rd_valid) saw_valid = 1'b1;
         if (d1_init_busy) c1++;
         if (d2_init_busy) c2++;
         if (d0_init_busy) begin
            c0++;
            if (drop_reqs) begin
               if (c0 == 10)       d0_drive(1'b1, 1'b1, 2'b11, 7'd3, 40'h1);
               else if (c0 == 11)  d0_drive(1'b1, 1'b0, 2'b00, 7'd3, 40'h0);
               else if (c0 == 128) d0_drive(1'b1, 1'b0, 2'b00, 7'd3, 40'h0);
               else                d0_drive(1'b0, 1'b0, 2'b00, 7'd0, 40'h0);
            end
         end
         if (!d0_init_busy && !d1_init_busy && !d2_init_busy) begin
            timeout = 1'b0;
            break;
         end
      end
      d0_drive(1'b0, 1'b0, 2'b00, 7'd0, 40'h0);
   endtask

   typedef struct {
      logic        ce;
      logic        we;
      logic [1:0]  wmask;
      logic [6:0]  addr;
      logic [39:0] din;
      logic        exp_valid;
      logic [39:0] exp_dout;
   } vec_t;

   vec_t vecs[18];

   int  c0, c1, c2;
   bit  saw, tmo;

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : main
      logic        r_exp_v [6];
      logic [39:0] r_exp_d [6];

      // ---------------- init sweep with dropped requests ----------------
      // NOTE: bench inputs use blocking assignments from procedural code,
      // placed after a falling edge so the DUT sees them stable at the next
      // rising edge.
      repeat (2) @(posedge clk);
      #2 rstb = 1'b1;
      run_init(1'b1, c0, c1, c2, saw, tmo);
      check("init_timeout", 64'(tmo), 64'd0);
      check("init_len_d0", 64'(c0), 64'd128);
      check("init_len_d1", 64'(c1), 64'd128);
      check("init_len_d2", 64'(c2), 64'd16);
      check("no_valid_during_init", 64'(saw), 64'd0);
      check("dout_after_init", 64'(d0_dout), 64'd0);

      // ---------------- table-driven d0 vectors ----------------
      vecs[0]  = '{1'b1, 1'b0, 2'b00, 7'd3,   40'h0,            1'b1, 40'h0};
      vecs[1]  = '{1'b1, 1'b0, 2'b00, 7'd0,   40'h0,            1'b1, 40'h0};
      vecs[2]  = '{1'b1, 1'b0, 2'b11, 7'd64,  40'hFF_FFFF_FFFF, 1'b1, 40'h0};
      vecs[3]  = '{1'b1, 1'b0, 2'b00, 7'd127, 40'h0,            1'b1, 40'h0};
      vecs[4]  = '{1'b1, 1'b1, 2'b11, 7'd5,   40'hAB_CDE1_2345, 1'b0, 40'h0};
      vecs[5]  = '{1'b1, 1'b1, 2'b01, 7'd5,   40'h00_0000_0000, 1'b0, 40'h0};
      vecs[6]  = '{1'b1, 1'b0, 2'b00, 7'd5,   40'h0,            1'b1, 40'hAB_CDE0_0000};
      vecs[7]  = '{1'b0, 1'b0, 2'b00, 7'd9,   40'h0,            1'b0, 40'hAB_CDE0_0000};
      vecs[8]  = '{1'b1, 1'b1, 2'b10, 7'd6,   40'h12_3456_789A, 1'b0, 40'hAB_CDE0_0000};
      vecs[9]  = '{1'b1, 1'b0, 2'b00, 7'd6,   40'h0,            1'b1, 40'h12_3450_0000};
      vecs[10] = '{1'b1, 1'b1, 2'b00, 7'd7,   40'hFF_FFFF_FFFF, 1'b0, 40'h12_3450_0000};
      vecs[11] = '{1'b1, 1'b0, 2'b00, 7'd7,   40'h0,            1'b1, 40'h0};
      vecs[12] = '{1'b1, 1'b0, 2'b00, 7'd5,   40'h0,            1'b1, 40'hAB_CDE0_0000};
      vecs[13] = '{1'b1, 1'b0, 2'b00, 7'd6,   40'h0,            1'b1, 40'h12_3450_0000};
      vecs[14] = '{1'b0, 1'b0, 2'b00, 7'd5,   40'h0,            1'b0, 40'h12_3450_0000};
      vecs[15] = '{1'b0, 1'b1, 2'b11, 7'd2,   40'h55_5555_5555, 1'b0, 40'h12_3450_0000};
      vecs[16] = '{1'b1, 1'b0, 2'b00, 7'd2,   40'h0,            1'b1, 40'h0};
      vecs[17] = '{1'b1, 1'b0, 2'b00, 7'd5,   40'h0,            1'b1, 40'hAB_CDE0_0000};

      for (int i = 0; i < 18; i++) begin
         d0_drive(vecs[i].ce, vecs[i].we, vecs[i].wmask, vecs[i].addr, vecs[i].din);
         @(negedge clk);
         check($sformatf("vec%0d_rd_valid", i), 64'(d0_rd_valid), 64'(vecs[i].exp_valid));
         check($sformatf("vec%0d_dout", i), 64'(d0_dout), 64'(vecs[i].exp_dout));
      end
      d0_drive(1'b0, 1'b0, 2'b00, 7'd0, 40'h0);

      // ---------------- OUT_REG=1 pipelining on d1 ----------------
      for (int i = 0; i < 4; i++) begin
         d1_ce = 1'b1; d1_we = 1'b1; d1_wmask = 2'b11;
         d1_addr = 7'(i); d1_din = 40'(10 + i);
         @(negedge clk);
      end
      check("oreg_valid_after_writes", 64'(d1_rd_valid), 64'd0);
      r_exp_v = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      r_exp_d = '{40'd0, 40'd10, 40'd11, 40'd12, 40'd13, 40'd13};
      for (int i = 0; i < 6; i++) begin
         d1_ce = (i < 4); d1_we = 1'b0; d1_wmask = 2'b00;
         d1_addr = 7'(i % 4); d1_din = 40'h0;
         @(negedge clk);
         check($sformatf("oreg_step%0d_rd_valid", i), 64'(d1_rd_valid), 64'(r_exp_v[i]));
         check($sformatf("oreg_step%0d_dout", i), 64'(d1_dout), 64'(r_exp_d[i]));
      end
      d1_ce = 1'b0;

      // ---------------- geometry variant on d2 ----------------
      d2_ce = 1'b1; d2_we = 1'b1; d2_wmask = 4'b1010; d2_addr = 4'd15; d2_din = 32'h11223344;
      @(negedge clk);
      check("geo_wr_no_valid", 64'(d2_rd_valid), 64'd0);
      d2_we = 1'b0; d2_wmask = 4'b0000; d2_din = 32'h0;
      @(negedge clk);
      check("geo_rd15_valid", 64'(d2_rd_valid), 64'd1);
      check("geo_rd15_dout", 64'(d2_dout), 64'h11AD33EF);
      d2_addr = 4'd0;
      @(negedge clk);
      check("geo_rd0_dout", 64'(d2_dout), 64'hDEADBEEF);
      d2_ce = 1'b0;
      @(negedge clk);
      check("geo_idle_valid", 64'(d2_rd_valid), 64'd0);
      check("geo_idle_dout_hold", 64'(d2_dout), 64'hDEADBEEF);

      // ---------------- asynchronous reset clears outputs ----------------
      #2 rstb = 1'b0;
      #1;
      check("async_rst_d0_dout", 64'(d0_dout), 64'd0);
      check("async_rst_d1_dout", 64'(d1_dout), 64'd0);
      check("async_rst_d2_dout", 64'(d2_dout), 64'd0);
      check("async_rst_d0_busy", 64'(d0_init_busy), 64'd1);

      // ---------------- mid-sweep reset ----------------
      @(posedge clk);
      #2 rstb = 1'b1;
      repeat (50) @(negedge clk);
      check("midsweep_busy_before", 64'(d0_init_busy), 64'd1);
      #2 rstb = 1'b0;
      #1;
      check("midsweep_busy_in_rst", 64'(d0_init_busy), 64'd1);
      check("midsweep_dout_in_rst", 64'(d0_dout), 64'd0);
      check("midsweep_valid_in_rst", 64'(d0_rd_valid), 64'd0);
      @(posedge clk);
      #2 rstb = 1'b1;
      run_init(1'b0, c0, c1, c2, saw, tmo);
      check("reinit_timeout", 64'(tmo), 64'd0);
      check("reinit_len_d0", 64'(c0), 64'd128);
      check("reinit_len_d2", 64'(c2), 64'd16);

      // Memory was rewritten by the fresh sweep.
      d0_drive(1'b1, 1'b0, 2'b00, 7'd5, 40'h0);
      d2_ce = 1'b1; d2_we = 1'b0; d2_addr = 4'd15;
      @(negedge clk);
      check("reinit_d0_addr5", 64'(d0_dout), 64'd0);
      check("reinit_d0_valid", 64'(d0_rd_valid), 64'd1);
      check("reinit_d2_addr15", 64'(d2_dout), 64'hDEADBEEF);
      d0_drive(1'b0, 1'b0, 2'b00, 7'd0, 40'h0);
      d2_ce = 1'b0;
      @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
